// File: rtl/pes_sipo_frame_rx.sv
// Serial-to-parallel frame receiver: start(1) | DATA_W bits LSB-first | even parity (opt) | stop(0).
// Word appears on data_out one cycle after the stop bit; a full output slot drops the frame with an overrun pulse.
module pes_sipo_frame_rx #(
  parameter int DATA_W    = 8,
  parameter int PARITY_EN = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              serial_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic HAS_PARITY = (PARITY_EN != 0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_acc_q, par_acc_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              perr_q, perr_d;
  logic              ferr_q, ferr_d;
  logic              ovr_q, ovr_d;
  logic              accept;

  assign accept = valid_q && data_ready;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_acc_d = par_acc_q;
    data_d    = data_q;
    valid_d   = valid_q;
    perr_d    = perr_q;
    ferr_d    = 1'b0;
    ovr_d     = 1'b0;

    if (accept) begin
      valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (serial_in) begin
          state_d   = ST_SHIFT;
          bit_cnt_d = '0;
          par_acc_d = 1'b0;
        end
      end

      ST_SHIFT: begin
        // First bit received walks down to bit 0 after DATA_W shifts.
        shift_d   = {serial_in, shift_q[DATA_W-1:1]};
        par_acc_d = par_acc_q ^ serial_in;
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
        if (bit_cnt_q == LAST_BIT) begin
          bit_cnt_d = '0;
          state_d   = HAS_PARITY ? ST_PARITY : ST_STOP;
        end
      end

      ST_PARITY: begin
        par_acc_d = par_acc_q ^ serial_in;
        state_d   = ST_STOP;
      end

      ST_STOP: begin
        // The stop-cycle bit is consumed here and never restarts a frame.
        state_d = ST_IDLE;
        if (!serial_in) begin
          if (!valid_q || accept) begin
            data_d  = shift_q;
            perr_d  = HAS_PARITY & par_acc_q;
            valid_d = 1'b1;
          end else begin
            ovr_d = 1'b1;
          end
        end else begin
          ferr_d = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_acc_q <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_acc_q <= par_acc_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_pes_sipo_frame_rx.sv
// Directed bench for pes_sipo_frame_rx (DATA_W=8, PARITY_EN=1); inputs change 1 time unit after each rising edge.
module tb_pes_sipo_frame_rx;

  logic       clk = 1'b0;
  logic       reset;
  logic       serial_in;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ready;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;

  int passes = 0;
  int total  = 0;

  pes_sipo_frame_rx #(.DATA_W(8), .PARITY_EN(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .serial_in  (serial_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Present one bit for one clock; returns 1 unit after the edge that sampled it.
  task automatic send_bit(input logic b);
    serial_in = b;
    @(posedge clk);
    #1;
  endtask

  // Start, 8 data bits LSB-first, parity, stop. data_ready may change only with the stop bit.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                            input logic set_rdy, input logic rdy_at_stop);
    send_bit(1'b1);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par);
    if (set_rdy) data_ready = rdy_at_stop;
    send_bit(stop);
  endtask

  initial begin
    reset      = 1'b1;
    serial_in  = 1'b1;
    data_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(data_valid), 32'h0);
    chk("rst_data",  32'(data_out),   32'h0);
    chk("rst_perr",  32'(parity_err), 32'h0);
    chk("rst_ferr",  32'(frame_err),  32'h0);
    chk("rst_ovr",   32'(overrun),    32'h0);
    reset     = 1'b0;
    serial_in = 1'b0;
    send_bit(1'b0);

    // Good frame A5, even parity 0
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("good_valid", 32'(data_valid), 32'h1);
    chk("good_data",  32'(data_out),   32'hA5);
    chk("good_perr",  32'(parity_err), 32'h0);
    chk("good_ferr",  32'(frame_err),  32'h0);
    send_bit(1'b0);
    chk("good_valid_drop", 32'(data_valid), 32'h0);

    // Same frame, wrong parity bit
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("perr_valid", 32'(data_valid), 32'h1);
    chk("perr_data",  32'(data_out),   32'hA5);
    chk("perr_flag",  32'(parity_err), 32'h1);
    send_bit(1'b0);

    // 3C with bad stop bit, then 01 recovers
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("ferr_pulse", 32'(frame_err),  32'h1);
    chk("ferr_valid", 32'(data_valid), 32'h0);
    send_bit(1'b0);
    chk("ferr_one_cycle", 32'(frame_err), 32'h0);
    send_frame(8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("after_ferr_valid", 32'(data_valid), 32'h1);
    chk("after_ferr_data",  32'(data_out),   32'h01);
    chk("after_ferr_perr",  32'(parity_err), 32'h0);
    send_bit(1'b0);

    // Backpressure: 11 then 22 back-to-back with data_ready low
    data_ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("bp_first_valid", 32'(data_valid), 32'h1);
    chk("bp_first_data",  32'(data_out),   32'h11);
    chk("bp_first_ovr",   32'(overrun),    32'h0);
    send_frame(8'h22, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("bp_ovr_pulse", 32'(overrun),    32'h1);
    chk("bp_hold_data", 32'(data_out),   32'h11);
    chk("bp_hold_vld",  32'(data_valid), 32'h1);
    send_bit(1'b0);
    chk("bp_ovr_one_cycle", 32'(overrun),    32'h0);
    chk("bp_still_valid",   32'(data_valid), 32'h1);
    data_ready = 1'b1;
    send_bit(1'b0);
    chk("bp_accept_drop", 32'(data_valid), 32'h0);

    // Accept and load in the same cycle
    data_ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("al_first_data", 32'(data_out), 32'h11);
    send_frame(8'h22, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("al_valid", 32'(data_valid), 32'h1);
    chk("al_data",  32'(data_out),   32'h22);
    chk("al_ovr",   32'(overrun),    32'h0);
    send_bit(1'b0);
    chk("al_drop", 32'(data_valid), 32'h0);

    // Reset in the middle of a frame while a word is held
    data_ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    reset = 1'b1;
    send_bit(1'b0);
    chk("mid_rst_valid", 32'(data_valid), 32'h0);
    chk("mid_rst_data",  32'(data_out),   32'h0);
    chk("mid_rst_perr",  32'(parity_err), 32'h0);
    chk("mid_rst_ovr",   32'(overrun),    32'h0);
    reset      = 1'b0;
    data_ready = 1'b1;
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("post_rst_valid", 32'(data_valid), 32'h1);
    chk("post_rst_data",  32'(data_out),   32'h5A);
    chk("post_rst_perr",  32'(parity_err), 32'h0);
    send_bit(1'b0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/pes_sipo_frame_rx.md
Name: pes_sipo_frame_rx

Overview:
Serial-to-parallel frame receiver that sits directly downstream of pes_siso and consumes its serial_out bit stream, one bit per clk.
- Detects a start bit, shifts in DATA_W data bits LSB-first, optionally checks even parity, and verifies the stop bit.
- Presents each received word on a valid/ready output port for the parallel consumer.

Parameters:
DATA_W, 8, number of data bits per frame (2..32)
PARITY_EN, 1, 1 = frame carries an even-parity bit after the data; 0 = no parity bit

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
serial_in  input  1  serial bit stream (from pes_siso serial_out), one bit per clock
data_out  output  DATA_W  received word, LSB = first data bit received
data_valid  output  1  data_out/parity_err hold a word not yet accepted
data_ready  input  1  consumer accepts the word when data_valid && data_ready
parity_err  output  1  qualifies data_out; 1 = parity check failed for this word
frame_err  output  1  one-cycle pulse: stop bit was wrong, frame discarded
overrun  output  1  one-cycle pulse: completed frame dropped because output was still occupied

Behaviour:
- Line protocol: idle level 0, start bit 1, DATA_W data bits LSB-first, parity bit (if PARITY_EN), stop bit 0. One bit per clk, no oversampling.
- FSM states:
  - IDLE: serial_in==1 -> SHIFT, bit counter cleared.
  - SHIFT: one data bit per cycle into the shift register; after DATA_W bits -> PARITY if PARITY_EN, else STOP.
  - PARITY: sample the parity bit -> STOP.
  - STOP: sample the stop bit -> IDLE unconditionally. The stop-cycle bit is never reused as a start bit.
- Parity: error when XOR of the data bits and the parity bit is 1 (even parity). With PARITY_EN=0, parity_err is always 0.
- Latency: start bit sampled in cycle T. Data bits in T+1..T+DATA_W. Parity in T+DATA_W+1. Stop in the following cycle S. data_valid rises at S+1 (registered).
- Stop bit ==0 (good frame):
  - If the output slot is free, or is being accepted in the same cycle S (data_valid && data_ready), load data_out/parity_err and set data_valid.
  - Otherwise drop the frame; keep the old word; pulse overrun at S+1.
- Stop bit ==1: discard the frame; data_valid/data_out unchanged; pulse frame_err at S+1.
- A word delivered with a parity error still asserts data_valid, with parity_err=1.
- Output handshake:
  - data_valid stays high and data_out/parity_err stay stable until data_valid && data_ready.
  - data_valid clears the cycle after acceptance unless a new word loads in that same edge.
  - data_ready is ignored while data_valid=0.
- Reception is independent of data_ready; the receiver never stalls the line.
- Reset (any state, including mid-frame):
  - FSM -> IDLE; bit counter and shift register -> 0.
  - data_out=0, data_valid=0, parity_err=0, frame_err=0, overrun=0.
  - The partial frame is lost. Reset takes priority over all other events.
- serial_in high on the first cycle after reset deasserts is treated as a start bit.

Test Plan:
- Good frame: with DATA_W=8, PARITY_EN=1, data_ready=1, drive the sequence below -> data_valid=1 for one cycle at S+1, data_out=8'hA5, parity_err=0, frame_err=0.
  - Sequence: 1 | 1,0,1,0,0,1,0,1 | 0 | 0 (start | data | parity | stop).
- Parity error: same frame but parity bit=1 -> data_out=8'hA5, data_valid=1, parity_err=1.
- Frame error: 8'h3C with correct parity bit 0, stop bit=1 -> no data_valid; frame_err high exactly one cycle; the next frame 8'h01 (parity 1) received correctly.
- Backpressure/overrun:
  - data_ready=0; send 8'h11 then 8'h22 back-to-back -> data_out holds 8'h11 with data_valid=1; overrun pulses once after 8'h22's stop bit.
  - Raise data_ready -> 8'h11 accepted, data_valid drops.
- Accept-and-load same cycle: hold data_valid with 8'h11; assert data_ready exactly in 8'h22's stop cycle -> 8'h22 loads, data_valid stays high, no overrun.
- Reset mid-frame: assert reset after 4 data bits -> all outputs 0 next cycle; a full 8'h5A frame sent after release -> data_out=8'h5A, parity_err=0.
